data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Data-memory responder that services the load/store requests issued by the multicycle control FSM (ld/sd) over a four-phase REQ/ACK handshake.
- Holds a 64-bit-word memory array with per-byte write enables.
- Inserts a configurable number of wait states so the control FSM is exercised against non-ideal memory latency.
- Sits between the datapath address/store-data registers and the memory-data register.

Parameters:
- DEPTH, 256, number of 64-bit words in the array.
- ADDR_W, 32, width of the byte address.
- WAIT_CYCLES, 2, wait states inserted between request capture and access (0 allowed).
- PROTECT_LIMIT, 32'h100, byte-address bound for the optional write-protect feature.

Ports:
- CLK  in  1  clock, all flops on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ  in  1  request; held high until ACK is seen, then dropped.
- WE  in  1  1 = store (sd), 0 = load (ld); sampled with REQ.
- ADDR  in  ADDR_W  byte address.
- WDATA  in  64  store data.
- BYTE_EN  in  8  per-byte write mask; bit i enables WDATA[8i+7:8i].
- ACK  out  1  response valid; held until REQ falls.
- RDATA  out  64  load data, valid while ACK=1.
- ERR  out  1  access rejected, valid while ACK=1.
- BUSY  out  1  high in WAIT and RESP.

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE, ACK=0, RDATA=0, ERR=0, BUSY=0, wait counter=0. Memory contents are not cleared. Reset mid-transaction aborts the transaction; a pending write is not performed.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with REQ=1: latch WE, ADDR, WDATA, BYTE_EN; load cnt=WAIT_CYCLES; go to WAIT.
  - REQ=0: stay.
- WAIT:
  - Inputs are ignored; the latched copies are used.
  - cnt!=0: cnt decrements.
  - cnt==0: perform the access at this edge; ACK<=1; go to RESP.
- Access decode:
  - index = ADDR[ADDR_W-1:3].
  - Illegal if ADDR[2:0]!=0 (misaligned) or index>=DEPTH.
  - Legal read: RDATA<=mem[index], ERR<=0.
  - Legal write: mem[index] bytes with BYTE_EN=1 are updated, others unchanged; RDATA<=0, ERR<=0.
  - Illegal: no array update, RDATA<=0, ERR<=1.
- RESP:
  - ACK, RDATA, ERR are held stable.
  - On an edge with REQ=0: ACK<=0, ERR<=0, go to IDLE. RDATA keeps its value until the next response.
  - While ACK=1, REQ high is treated as the same transaction and never as a new request.
- Latency: with REQ sampled at edge k, ACK rises after edge k+1+WAIT_CYCLES (k+3 at default).
- Throughput: the next request is captured no earlier than the edge after the one that cleared ACK.
- WAIT_CYCLES=0: the WAIT state lasts exactly one cycle with cnt=0.
- Counter width: max(1, $clog2(WAIT_CYCLES+1)).
- BYTE_EN=0 on a write: legal, ACK with ERR=0, memory unchanged.

Optional Feature:
- Macro DATA_MEM_RESP_WRITE_PROTECT_EN.
- Defined: a write to any byte address < PROTECT_LIMIT is illegal. It receives ERR=1 and memory is unchanged. Reads there are unaffected.
- Undefined: PROTECT_LIMIT is ignored; only the misaligned and out-of-range checks apply.

Test Plan:
- Reset/idle: RST_N low mid-WAIT of a write to 0x10 → ACK=0, BUSY=0, RDATA=0 immediately; subsequent read of 0x10 returns its pre-write value.
- Write then read: sd 0x18, WDATA=64'h1122334455667788, BYTE_EN=8'hFF → ACK after edge k+3, ERR=0; ld 0x18 → RDATA=64'h1122334455667788.
- Byte mask: write 64'hFFFFFFFFFFFFFFFF to 0x20 with BYTE_EN=8'hFF, then 64'h0 with BYTE_EN=8'h0F → read 0x20 returns 64'hFFFFFFFF00000000.
- Errors: ld 0x1C (misaligned) → ERR=1, RDATA=0; sd at byte address DEPTH*8 → ERR=1, no word modified.
- Handshake: hold REQ high 5 cycles after ACK → ACK stays 1, no second access occurs; drop REQ → ACK=0 next edge, and a new REQ is accepted on the following edge.
- Protect (macro on, PROTECT_LIMIT=0x100): sd 0x80 → ERR=1, memory unchanged; ld 0x80 → ERR=0; sd 0x100 → ERR=0. With macro off: sd 0x80 → ERR=0 and the data is written.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Load/store request bus between the multicycle control FSM and the data-memory responder.
// The control FSM is the master; the responder is the slave.
interface data_mem_responder_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              REQ;
  logic              WE;
  logic [ADDR_W-1:0] ADDR;
  logic [63:0]       WDATA;
  logic [7:0]        BYTE_EN;
  logic              ACK;
  logic [63:0]       RDATA;
  logic              ERR;
  logic              BUSY;

  modport master (
    output REQ, WE, ADDR, WDATA, BYTE_EN,
    input  ACK, RDATA, ERR, BUSY
  );

  modport slave (
    input  REQ, WE, ADDR, WDATA, BYTE_EN,
    output ACK, RDATA, ERR, BUSY
  );
endinterface

// File: rtl/data_mem_responder.sv
// 64-bit word data memory answering ld/sd over a four-phase REQ/ACK handshake with wait states.
// Define DATA_MEM_RESP_WRITE_PROTECT_EN to reject stores below PROTECT_LIMIT.
module data_mem_responder #(
  parameter int unsigned       DEPTH         = 256,
  parameter int unsigned       ADDR_W        = 32,
  parameter int unsigned       WAIT_CYCLES   = 2,
  parameter logic [ADDR_W-1:0] PROTECT_LIMIT = ADDR_W'('h100)
) (
  input logic                 CLK,
  input logic                 RST_N,
  data_mem_responder_if.slave bus
);

  localparam int unsigned CntW = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int unsigned IdxW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);

`ifdef DATA_MEM_RESP_WRITE_PROTECT_EN
  localparam bit ProtectEn = 1'b1;
`else
  localparam bit ProtectEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [7:0]        ben_q;
  logic              ack_q, ack_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              latch_en;
  logic              mem_we;

  logic [63:0]       mem [DEPTH];

  logic [ADDR_W-4:0] idx_full;
  logic [IdxW-1:0]   mem_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              protect_hit;
  logic              illegal;

  assign idx_full     = addr_q[ADDR_W-1:3];
  assign mem_idx      = idx_full[IdxW-1:0];
  assign misaligned   = |addr_q[2:0];
  assign out_of_range = {3'b000, idx_full} >= ADDR_W'(DEPTH);
  assign protect_hit  = ProtectEn && we_q && (addr_q < PROTECT_LIMIT);
  assign illegal      = misaligned || out_of_range || protect_hit;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_d    = ack_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    latch_en = 1'b0;
    mem_we   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.REQ) begin
          latch_en = 1'b1;
          cnt_d    = CntW'(WAIT_CYCLES);
          state_d  = StWait;
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          ack_d   = 1'b1;
          state_d = StResp;
          if (illegal) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end else if (we_q) begin
            mem_we  = 1'b1;
            rdata_d = '0;
            err_d   = 1'b0;
          end else begin
            rdata_d = mem[mem_idx];
            err_d   = 1'b0;
          end
        end
      end
      StResp: begin
        // A REQ still high here belongs to the transaction being acknowledged.
        if (!bus.REQ) begin
          ack_d   = 1'b0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ben_q   <= '0;
    end else if (latch_en) begin
      we_q    <= bus.WE;
      addr_q  <= bus.ADDR;
      wdata_q <= bus.WDATA;
      ben_q   <= bus.BYTE_EN;
    end
  end

  // Array is deliberately left out of reset; contents survive RST_N.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (ben_q[b]) mem[mem_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign bus.ACK   = ack_q;
  assign bus.RDATA = rdata_q;
  assign bus.ERR   = err_q;
  assign bus.BUSY  = (state_q != StIdle);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder at default parameters.
// Expectations follow DATA_MEM_RESP_WRITE_PROTECT_EN when it is defined.
module tb_data_mem_responder;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  data_mem_responder_if #(.ADDR_W(32)) bus ();

  data_mem_responder #(
    .DEPTH        (256),
    .ADDR_W       (32),
    .WAIT_CYCLES  (2),
    .PROTECT_LIMIT(32'h100)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Presents a request before the next edge and returns #1 after the capture edge.
  task automatic start_req(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                           input logic [7:0] ben);
    @(negedge CLK);
    bus.WE      = we;
    bus.ADDR    = addr;
    bus.WDATA   = wdata;
    bus.BYTE_EN = ben;
    bus.REQ     = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // Counts edges after the capture edge until ACK is seen.
  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      @(posedge CLK);
      #1;
      lat++;
    end while (!bus.ACK && lat < 30);
    if (lat >= 30) check("ack_timeout", {63'd0, bus.ACK}, 64'd1);
  endtask

  task automatic end_req();
    @(negedge CLK);
    bus.REQ = 1'b0;
    @(posedge CLK);
    #1;
    check("ack_drop", {63'd0, bus.ACK}, 64'd0);
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                     input logic [7:0] ben, output logic [63:0] rd, output logic err,
                     output int lat);
    start_req(we, addr, wdata, ben);
    wait_ack(lat);
    rd  = bus.RDATA;
    err = bus.ERR;
    end_req();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic        err;
    int          lat;

    bus.REQ     = 1'b0;
    bus.WE      = 1'b0;
    bus.ADDR    = '0;
    bus.WDATA   = '0;
    bus.BYTE_EN = '0;

    #2 RST_N = 1'b0;
    #1;
    check("rst_ack",   {63'd0, bus.ACK},  64'd0);
    check("rst_err",   {63'd0, bus.ERR},  64'd0);
    check("rst_busy",  {63'd0, bus.BUSY}, 64'd0);
    check("rst_rdata", bus.RDATA,         64'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // Baseline contents for 0x10, then abort a write to it mid-WAIT.
    txn(1'b1, 32'h10, 64'hA5A5_5A5A_0123_4567, 8'hFF, rd, err, lat);
    check("init10_err", {63'd0, err}, 64'd0);
    check("init10_lat", 64'(lat), 64'd3);
    txn(1'b0, 32'h10, '0, '0, rd, err, lat);
    check("init10_rd", rd, 64'hA5A5_5A5A_0123_4567);
    start_req(1'b1, 32'h10, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    check("abort_busy", {63'd0, bus.BUSY}, 64'd1);
    @(posedge CLK);
    #3;
    RST_N   = 1'b0;
    bus.REQ = 1'b0;
    #1;
    check("abort_ack",   {63'd0, bus.ACK},  64'd0);
    check("abort_busy0", {63'd0, bus.BUSY}, 64'd0);
    check("abort_rdata", bus.RDATA,         64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    txn(1'b0, 32'h10, '0, '0, rd, err, lat);
    check("abort_keep", rd, 64'hA5A5_5A5A_0123_4567);

    // Full-word write then read.
    txn(1'b1, 32'h18, 64'h1122_3344_5566_7788, 8'hFF, rd, err, lat);
    check("wr18_lat", 64'(lat), 64'd3);
    check("wr18_err", {63'd0, err}, 64'd0);
    check("wr18_rd0", rd, 64'd0);
    txn(1'b0, 32'h18, '0, '0, rd, err, lat);
    check("rd18_lat", 64'(lat), 64'd3);
    check("rd18_err", {63'd0, err}, 64'd0);
    check("rd18", rd, 64'h1122_3344_5566_7788);

    // Empty byte mask is a legal no-op.
    txn(1'b1, 32'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, rd, err, lat);
    check("ben0_err", {63'd0, err}, 64'd0);
    txn(1'b0, 32'h18, '0, '0, rd, err, lat);
    check("ben0_keep", rd, 64'h1122_3344_5566_7788);

    // Partial byte mask.
    txn(1'b1, 32'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, err, lat);
    txn(1'b1, 32'h20, 64'h0, 8'h0F, rd, err, lat);
    txn(1'b0, 32'h20, '0, '0, rd, err, lat);
    check("mask20", rd, 64'hFFFF_FFFF_0000_0000);

    // Misaligned load.
    txn(1'b0, 32'h1C, '0, '0, rd, err, lat);
    check("mis_err", {63'd0, err}, 64'd1);
    check("mis_rd",  rd, 64'd0);
    check("mis_errclr", {63'd0, bus.ERR}, 64'd0);

    // Out-of-range store must not alias onto word 0 or the last word.
    txn(1'b1, 32'h0,   64'h0000_0000_0000_00AA, 8'hFF, rd, err, lat);
    txn(1'b1, 32'h7F8, 64'h0000_0000_0000_00BB, 8'hFF, rd, err, lat);
    txn(1'b1, 32'h800, 64'h5555_5555_5555_5555, 8'hFF, rd, err, lat);
    check("oor_err", {63'd0, err}, 64'd1);
    txn(1'b0, 32'h0, '0, '0, rd, err, lat);
    check("oor_w0", rd, 64'hAA);
    txn(1'b0, 32'h7F8, '0, '0, rd, err, lat);
    check("oor_wlast", rd, 64'hBB);
    txn(1'b0, 32'h800, '0, '0, rd, err, lat);
    check("oor_rd_err", {63'd0, err}, 64'd1);

    // REQ held after ACK: inputs change to a store, which must not happen.
    start_req(1'b0, 32'h18, '0, '0);
    wait_ack(lat);
    check("hold_rd", bus.RDATA, 64'h1122_3344_5566_7788);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      bus.WE      = 1'b1;
      bus.WDATA   = 64'(i) + 64'hCAFE_0000;
      bus.BYTE_EN = 8'hFF;
      @(posedge CLK);
      #1;
      check("hold_ack", {63'd0, bus.ACK}, 64'd1);
      check("hold_rdata", bus.RDATA, 64'h1122_3344_5566_7788);
    end
    @(negedge CLK);
    bus.REQ = 1'b0;
    @(posedge CLK);
    #1;
    check("hold_drop_ack",  {63'd0, bus.ACK},  64'd0);
    check("hold_drop_busy", {63'd0, bus.BUSY}, 64'd0);
    check("hold_rdata_keep", bus.RDATA, 64'h1122_3344_5566_7788);
    start_req(1'b0, 32'h18, '0, '0);
    check("next_busy", {63'd0, bus.BUSY}, 64'd1);
    wait_ack(lat);
    check("next_lat", 64'(lat), 64'd3);
    check("next_rd", bus.RDATA, 64'h1122_3344_5566_7788);
    end_req();

    // Write-protect region.
    txn(1'b1, 32'h80, 64'h8080_8080_8080_8080, 8'hFF, rd, err, lat);
`ifdef DATA_MEM_RESP_WRITE_PROTECT_EN
    check("prot_wr_err", {63'd0, err}, 64'd1);
    txn(1'b0, 32'h80, '0, '0, rd, err, lat);
    check("prot_rd_err", {63'd0, err}, 64'd0);
    check("prot_rd_keep", {63'd0, rd == 64'h8080_8080_8080_8080}, 64'd0);
`else
    check("prot_wr_err", {63'd0, err}, 64'd0);
    txn(1'b0, 32'h80, '0, '0, rd, err, lat);
    check("prot_rd_err", {63'd0, err}, 64'd0);
    check("prot_rd", rd, 64'h8080_8080_8080_8080);
`endif
    txn(1'b1, 32'h100, 64'h0100_0100_0100_0100, 8'hFF, rd, err, lat);
    check("lim_wr_err", {63'd0, err}, 64'd0);
    txn(1'b0, 32'h100, '0, '0, rd, err, lat);
    check("lim_rd", rd, 64'h0100_0100_0100_0100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
